// File: rtl/instr_decode_stage_pkg.sv
// rtl/instr_decode_stage_pkg.sv - decode stage opcodes, decoded enums, field struct and immediate helper
package instr_decode_stage_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [3:0] {
    OP_NO_OP, OP_COMP, OP_COMP_IMM, OP_STORE, OP_LOAD,
    OP_BRANCH, OP_JALR, OP_JAL, OP_AUIPC, OP_LUI
  } decoded_opcode;

  typedef enum logic [5:0] {
    INSTR_NO_OP, INSTR_BAD_INSTR,
    INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU, INSTR_XOR, INSTR_SRL, INSTR_SRA,
    INSTR_OR, INSTR_AND,
    INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU, INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU,
    INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
    INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
    INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
    INSTR_SB, INSTR_SH, INSTR_SW,
    INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
    INSTR_JALR, INSTR_JAL, INSTR_LUI, INSTR_AUIPC, INSTR_FENCE, INSTR_FENCEI
  } decoded_instr;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT
  } imm_type;

  typedef struct packed {
    decoded_opcode opcode;
    decoded_instr  instr;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic          rs1_used;
    logic          rs2_used;
    logic          rd_we;
    logic [31:0]   imm;
    logic          illegal;
  } decoded_fields;

  localparam decoded_fields DECODED_RESET = '{
    opcode: OP_NO_OP, instr: INSTR_NO_OP, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
    rs1_used: 1'b0, rs2_used: 1'b0, rd_we: 1'b0, imm: 32'd0, illegal: 1'b0
  };

  // Sign-extended immediate for each encoding format; shift amounts are zero-extended.
  function automatic logic [31:0] gen_imm(input imm_type t, input logic [31:0] i);
    case (t)
      IMM_I:     return {{20{i[31]}}, i[31:20]};
      IMM_S:     return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:     return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:     return {i[31:12], 12'b0};
      IMM_J:     return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_SHAMT: return {27'b0, i[24:20]};
      default:   return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// rtl/instr_decode_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface instr_decode_stage_if;
  import instr_decode_stage_pkg::*;

  logic          flush;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic          id_valid;
  logic          id_ready;
  logic [31:0]   id_pc;
  decoded_opcode id_opcode;
  decoded_instr  id_instr;
  logic [4:0]    id_rs1;
  logic [4:0]    id_rs2;
  logic [4:0]    id_rd;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic          id_rd_we;
  logic [31:0]   id_imm;
  logic          id_illegal;

  // Surrounding pipeline: fetch + execute + redirect source.
  modport master (
    output flush, if_valid, if_instr, if_pc, id_ready,
    input  if_ready, id_valid, id_pc, id_opcode, id_instr, id_rs1, id_rs2, id_rd,
           id_rs1_used, id_rs2_used, id_rd_we, id_imm, id_illegal
  );

  // The decode stage itself.
  modport slave (
    input  flush, if_valid, if_instr, if_pc, id_ready,
    output if_ready, id_valid, id_pc, id_opcode, id_instr, id_rs1, id_rs2, id_rd,
           id_rs1_used, id_rs2_used, id_rd_we, id_imm, id_illegal
  );
endinterface

// File: rtl/instr_decode_stage_decoder.sv
// rtl/instr_decode_stage_decoder.sv - combinational RV32I(+M) raw word to decoded fields
module instr_decoder
  import instr_decode_stage_pkg::*;
#(
  parameter bit M_EXT    = 1'b1,
  parameter bit ZIFENCEI = 1'b1
) (
  input  logic [31:0]   instr,
  output decoded_fields dec
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       bad;
  logic       has_rd;
  imm_type    it;

  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  // Classify the word, then derive register usage; illegal words collapse to a clean bubble.
  always_comb begin
    dec    = DECODED_RESET;
    bad    = 1'b0;
    has_rd = 1'b0;
    it     = IMM_NONE;
    // Every known opcode ends in 2'b11, so compressed/short encodings land in the default arm.
    case (instr[6:0])
      OPC_OP: begin
        dec.opcode = OP_COMP;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: dec.instr = INSTR_ADD;
            3'b001: dec.instr = INSTR_SLL;
            3'b010: dec.instr = INSTR_SLT;
            3'b011: dec.instr = INSTR_SLTU;
            3'b100: dec.instr = INSTR_XOR;
            3'b101: dec.instr = INSTR_SRL;
            3'b110: dec.instr = INSTR_OR;
            3'b111: dec.instr = INSTR_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) dec.instr = INSTR_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101) dec.instr = INSTR_SRA;
        else if (f7 == 7'b0000001 && M_EXT) begin
          case (f3)
            3'b000: dec.instr = INSTR_MUL;
            3'b001: dec.instr = INSTR_MULH;
            3'b010: dec.instr = INSTR_MULHSU;
            3'b011: dec.instr = INSTR_MULHU;
            3'b100: dec.instr = INSTR_DIV;
            3'b101: dec.instr = INSTR_DIVU;
            3'b110: dec.instr = INSTR_REM;
            3'b111: dec.instr = INSTR_REMU;
          endcase
        end else bad = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.opcode = OP_COMP_IMM;
        it = IMM_I;
        case (f3)
          3'b000: dec.instr = INSTR_ADDI;
          3'b010: dec.instr = INSTR_SLTI;
          3'b011: dec.instr = INSTR_SLTIU;
          3'b100: dec.instr = INSTR_XORI;
          3'b110: dec.instr = INSTR_ORI;
          3'b111: dec.instr = INSTR_ANDI;
          3'b001: begin
            it = IMM_SHAMT;
            dec.instr = INSTR_SLLI;
            bad = (f7 != 7'b0000000);
          end
          3'b101: begin
            it = IMM_SHAMT;
            if (f7 == 7'b0000000) dec.instr = INSTR_SRLI;
            else if (f7 == 7'b0100000) dec.instr = INSTR_SRAI;
            else bad = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        dec.opcode = OP_LOAD;
        it = IMM_I;
        case (f3)
          3'b000:  dec.instr = INSTR_LB;
          3'b001:  dec.instr = INSTR_LH;
          3'b010:  dec.instr = INSTR_LW;
          3'b100:  dec.instr = INSTR_LBU;
          3'b101:  dec.instr = INSTR_LHU;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.opcode = OP_STORE;
        it = IMM_S;
        case (f3)
          3'b000:  dec.instr = INSTR_SB;
          3'b001:  dec.instr = INSTR_SH;
          3'b010:  dec.instr = INSTR_SW;
          default: bad = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        dec.opcode = OP_BRANCH;
        it = IMM_B;
        case (f3)
          3'b000:  dec.instr = INSTR_BEQ;
          3'b001:  dec.instr = INSTR_BNE;
          3'b100:  dec.instr = INSTR_BLT;
          3'b101:  dec.instr = INSTR_BGE;
          3'b110:  dec.instr = INSTR_BLTU;
          3'b111:  dec.instr = INSTR_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_JALR: begin
        dec.opcode = OP_JALR;
        dec.instr  = INSTR_JALR;
        it = IMM_I;
        bad = (f3 != 3'b000);
      end
      OPC_JAL:   begin dec.opcode = OP_JAL;   dec.instr = INSTR_JAL;   it = IMM_J; end
      OPC_AUIPC: begin dec.opcode = OP_AUIPC; dec.instr = INSTR_AUIPC; it = IMM_U; end
      OPC_LUI:   begin dec.opcode = OP_LUI;   dec.instr = INSTR_LUI;   it = IMM_U; end
      OPC_MISC_MEM: begin
        dec.opcode = OP_NO_OP;
        if (f3 == 3'b000) dec.instr = INSTR_FENCE;
        else if (f3 == 3'b001 && ZIFENCEI) dec.instr = INSTR_FENCEI;
        else bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    // Fences are classed OP_NO_OP and read no register.
    dec.rs2_used = dec.opcode inside {OP_COMP, OP_STORE, OP_BRANCH};
    dec.rs1_used = !(dec.opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_NO_OP});
    has_rd       = dec.opcode inside {OP_COMP, OP_COMP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    dec.rs1      = dec.rs1_used ? instr[19:15] : 5'd0;
    dec.rs2      = dec.rs2_used ? instr[24:20] : 5'd0;
    dec.rd       = has_rd ? instr[11:7] : 5'd0;
    dec.rd_we    = has_rd && (instr[11:7] != 5'd0);
    dec.imm      = gen_imm(it, instr);

    if (bad) begin
      dec         = DECODED_RESET;
      dec.instr   = INSTR_BAD_INSTR;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - decode pipeline stage: handshake, output register and flush around the decoder
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter bit M_EXT    = 1'b1,
  parameter bit ZIFENCEI = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_decode_stage_if.slave  bus
);

  decoded_fields dec;
  decoded_fields held;
  logic          held_valid;
  logic [31:0]   held_pc;
  logic          accept;

  instr_decoder #(
    .M_EXT    (M_EXT),
    .ZIFENCEI (ZIFENCEI)
  ) u_decoder (
    .instr (bus.if_instr),
    .dec   (dec)
  );

  // The slot frees up in the same cycle execute takes the held word, giving full throughput.
  assign bus.if_ready = !held_valid || bus.id_ready;
  assign accept       = bus.if_valid && bus.if_ready;

  // Output register: flush beats capture; only id_valid drops on flush, the payload is left as is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_valid <= 1'b0;
      held       <= DECODED_RESET;
      held_pc    <= 32'd0;
    end else if (bus.flush) begin
      held_valid <= 1'b0;
    end else if (accept) begin
      held_valid <= 1'b1;
      held       <= dec;
      held_pc    <= bus.if_pc;
    end else if (bus.id_ready) begin
      held_valid <= 1'b0;
    end
  end

  assign bus.id_valid    = held_valid;
  assign bus.id_pc       = held_pc;
  assign bus.id_opcode   = held.opcode;
  assign bus.id_instr    = held.instr;
  assign bus.id_rs1      = held.rs1;
  assign bus.id_rs2      = held.rs2;
  assign bus.id_rd       = held.rd;
  assign bus.id_rs1_used = held.rs1_used;
  assign bus.id_rs2_used = held.rs2_used;
  assign bus.id_rd_we    = held.rd_we;
  assign bus.id_imm      = held.imm;
  assign bus.id_illegal  = held.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - scoreboard bench for instr_decode_stage
module tb_instr_decode_stage;
  import instr_decode_stage_pkg::*;

  typedef struct {
    logic [31:0]   word;
    decoded_instr  ins;
    decoded_opcode op;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic [3:0]    flg;   // {rs1_used, rs2_used, rd_we, illegal}
    logic [31:0]   imm;
    logic [31:0]   pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t tbl[$];
  exp_t q[$];
  exp_t cur_exp;
  exp_t mon_e;
  logic took;
  int   cyc;

  instr_decode_stage_if bus ();
  instr_decode_stage_if bus0 ();

  instr_decode_stage #(.M_EXT(1'b1), .ZIFENCEI(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  instr_decode_stage #(.M_EXT(1'b0), .ZIFENCEI(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] w, input decoded_instr i, input decoded_opcode o,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                              input logic [3:0] f, input logic [31:0] im);
    exp_t e;
    e.word = w; e.ins = i; e.op = o; e.rs1 = r1; e.rs2 = r2; e.rd = d;
    e.flg = f; e.imm = im; e.pc = 32'd0;
    return e;
  endfunction

  task automatic compare_out(input exp_t e);
    string t;
    t = $sformatf("%h", e.word);
    check({t, " pc"},     64'(bus.id_pc), 64'(e.pc));
    check({t, " instr"},  64'(bus.id_instr), 64'(e.ins));
    check({t, " opcode"}, 64'(bus.id_opcode), 64'(e.op));
    check({t, " regs"},   64'({bus.id_rs1, bus.id_rs2, bus.id_rd}), 64'({e.rs1, e.rs2, e.rd}));
    check({t, " flags"},  64'({bus.id_rs1_used, bus.id_rs2_used, bus.id_rd_we, bus.id_illegal}), 64'(e.flg));
    check({t, " imm"},    64'(bus.id_imm), 64'(e.imm));
  endtask

  // One clock: scoreboard update at the falling edge, then settle just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      q.delete();
      took = 1'b0;
    end else begin
      if (bus.id_valid) begin
        if (q.size() == 0) check("spurious_valid", 64'(bus.id_valid), 64'(0));
        else if (bus.id_ready) begin
          mon_e = q.pop_front();
          compare_out(mon_e);
        end else if (bus.flush) void'(q.pop_front());
        else begin
          check("hold_pc", 64'(bus.id_pc), 64'(q[0].pc));
          check("hold_instr", 64'(bus.id_instr), 64'(q[0].ins));
        end
      end
      took = bus.if_valid && bus.if_ready && !bus.flush;
      if (took) begin
        mon_e = cur_exp;
        mon_e.pc = bus.if_pc;
        q.push_back(mon_e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int idx, input logic [31:0] pc);
    cur_exp = tbl[idx];
    bus.if_instr = cur_exp.word;
    bus.if_pc = pc;
  endtask

  task automatic run_stream(input int n, input int pv, input int pr, output int cycles);
    int sent = 0;
    cycles = 0;
    while ((sent < n || q.size() > 0) && cycles < 4000) begin
      present(sent % tbl.size(), 32'h1000 + 32'(sent * 4));
      bus.if_valid = (sent < n) && ($urandom_range(99) < pv);
      bus.id_ready = ($urandom_range(99) < pr);
      tick();
      cycles++;
      if (took) sent++;
    end
    check("stream_done", 64'(sent == n && q.size() == 0), 64'(1));
    bus.if_valid = 1'b0;
    bus.id_ready = 1'b1;
    tick();
  endtask

  initial begin
    tbl.push_back(mk(32'h00500093, INSTR_ADDI,      OP_COMP_IMM, 0, 0, 1,  4'b1010, 32'd5));
    tbl.push_back(mk(32'hFE208EE3, INSTR_BEQ,       OP_BRANCH,   1, 2, 0,  4'b1100, 32'hFFFFFFFC));
    tbl.push_back(mk(32'h022081B3, INSTR_MUL,       OP_COMP,     1, 2, 3,  4'b1110, 32'd0));
    tbl.push_back(mk(32'h007302B3, INSTR_ADD,       OP_COMP,     6, 7, 5,  4'b1110, 32'd0));
    tbl.push_back(mk(32'h407302B3, INSTR_SUB,       OP_COMP,     6, 7, 5,  4'b1110, 32'd0));
    tbl.push_back(mk(32'h403150B3, INSTR_SRA,       OP_COMP,     2, 3, 1,  4'b1110, 32'd0));
    tbl.push_back(mk(32'h403110B3, INSTR_BAD_INSTR, OP_NO_OP,    0, 0, 0,  4'b0001, 32'd0));
    tbl.push_back(mk(32'hFF812503, INSTR_LW,        OP_LOAD,     2, 0, 10, 4'b1010, 32'hFFFFFFF8));
    tbl.push_back(mk(32'h0071A623, INSTR_SW,        OP_STORE,    3, 7, 0,  4'b1100, 32'd12));
    tbl.push_back(mk(32'h12345237, INSTR_LUI,       OP_LUI,      0, 0, 4,  4'b0010, 32'h12345000));
    tbl.push_back(mk(32'h008000EF, INSTR_JAL,       OP_JAL,      0, 0, 1,  4'b0010, 32'd8));
    tbl.push_back(mk(32'hFF1FF06F, INSTR_JAL,       OP_JAL,      0, 0, 0,  4'b0000, 32'hFFFFFFF0));
    tbl.push_back(mk(32'h41F25193, INSTR_SRAI,      OP_COMP_IMM, 4, 0, 3,  4'b1010, 32'd31));
    tbl.push_back(mk(32'h40109093, INSTR_BAD_INSTR, OP_NO_OP,    0, 0, 0,  4'b0001, 32'd0));
    tbl.push_back(mk(32'h00500090, INSTR_BAD_INSTR, OP_NO_OP,    0, 0, 0,  4'b0001, 32'd0));
    tbl.push_back(mk(32'h0FF0000F, INSTR_FENCE,     OP_NO_OP,    0, 0, 0,  4'b0000, 32'd0));
    tbl.push_back(mk(32'h0000100F, INSTR_FENCEI,    OP_NO_OP,    0, 0, 0,  4'b0000, 32'd0));
    tbl.push_back(mk(32'h004280E7, INSTR_JALR,      OP_JALR,     5, 0, 1,  4'b1010, 32'd4));
    tbl.push_back(mk(32'hFFFFF117, INSTR_AUIPC,     OP_AUIPC,    0, 0, 2,  4'b0010, 32'hFFFFF000));
    tbl.push_back(mk(32'h0020A063, INSTR_BAD_INSTR, OP_NO_OP,    0, 0, 0,  4'b0001, 32'd0));
    tbl.push_back(mk(32'h00000073, INSTR_BAD_INSTR, OP_NO_OP,    0, 0, 0,  4'b0001, 32'd0));
    tbl.push_back(mk(32'h004290E7, INSTR_BAD_INSTR, OP_NO_OP,    0, 0, 0,  4'b0001, 32'd0));

    rst = 1'b1;
    took = 1'b0;
    cur_exp = tbl[0];
    bus.flush = 1'b0;  bus.if_valid = 1'b0;  bus.if_instr = 32'd0;  bus.if_pc = 32'd0;  bus.id_ready = 1'b0;
    bus0.flush = 1'b0; bus0.if_valid = 1'b0; bus0.if_instr = 32'd0; bus0.if_pc = 32'd0; bus0.id_ready = 1'b0;
    tick();
    tick();

    check("rst_valid",  64'(bus.id_valid), 64'(0));
    check("rst_opcode", 64'(bus.id_opcode), 64'(OP_NO_OP));
    check("rst_instr",  64'(bus.id_instr), 64'(INSTR_NO_OP));
    check("rst_fields", 64'({bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_rs1_used, bus.id_rs2_used,
                             bus.id_rd_we, bus.id_illegal}), 64'(0));
    check("rst_imm_pc", {bus.id_imm, bus.id_pc}, 64'(0));
    check("rst_if_ready", 64'(bus.if_ready), 64'(1));
    rst = 1'b0;

    // Variant without M extension and without FENCE.I.
    bus0.if_valid = 1'b1;
    bus0.id_ready = 1'b1;
    bus0.if_instr = 32'h022081B3;
    tick();
    check("noM_mul_illegal", 64'(bus0.id_illegal), 64'(1));
    check("noM_mul_instr", 64'(bus0.id_instr), 64'(INSTR_BAD_INSTR));
    check("noM_mul_opcode", 64'(bus0.id_opcode), 64'(OP_NO_OP));
    bus0.if_instr = 32'h0000100F;
    tick();
    check("noZi_fencei_instr", 64'(bus0.id_instr), 64'(INSTR_BAD_INSTR));
    bus0.if_instr = 32'h407302B3;
    tick();
    check("noM_sub_instr", 64'(bus0.id_instr), 64'(INSTR_SUB));
    check("noM_sub_illegal", 64'(bus0.id_illegal), 64'(0));
    bus0.if_valid = 1'b0;

    // addi: one-cycle latency.
    present(0, 32'h0000_0100);
    bus.if_valid = 1'b1;
    bus.id_ready = 1'b1;
    tick();
    check("addi_latency", 64'(bus.id_valid), 64'(1));
    bus.if_valid = 1'b0;
    tick();
    check("addi_drained", 64'(bus.id_valid), 64'(0));

    // Back-to-back with execute always ready: one word per cycle.
    run_stream(tbl.size(), 100, 100, cyc);
    check("throughput_cycles", 64'(cyc), 64'(tbl.size() + 1));

    // Random valid/ready over several passes of the table.
    run_stream(3 * tbl.size(), 70, 60, cyc);

    // Stall three cycles with fetch pushing; both words must come out once, in order.
    present(3, 32'h2000);
    bus.if_valid = 1'b1;
    bus.id_ready = 1'b0;
    tick();
    present(4, 32'h2004);
    for (int i = 0; i < 3; i++) begin
      check("stall_if_ready", 64'(bus.if_ready), 64'(0));
      tick();
    end
    bus.id_ready = 1'b1;
    tick();
    bus.if_valid = 1'b0;
    tick();
    check("stall_drained", 64'(q.size()), 64'(0));
    check("stall_valid", 64'(bus.id_valid), 64'(0));

    // Flush while holding and while fetch offers a word: both are dropped.
    present(7, 32'h3000);
    bus.if_valid = 1'b1;
    bus.id_ready = 1'b0;
    tick();
    present(8, 32'h3004);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    bus.id_ready = 1'b1;
    check("flush_valid", 64'(bus.id_valid), 64'(0));
    check("flush_sb_empty", 64'(q.size()), 64'(0));
    tick();
    check("flush_stays_idle", 64'(bus.id_valid), 64'(0));

    // Asynchronous reset with a word held.
    present(9, 32'h4000);
    bus.if_valid = 1'b1;
    bus.id_ready = 1'b0;
    tick();
    bus.if_valid = 1'b0;
    check("pre_rst_valid", 64'(bus.id_valid), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(bus.id_valid), 64'(0));
    check("mid_rst_instr", 64'(bus.id_instr), 64'(INSTR_NO_OP));
    check("mid_rst_opcode", 64'(bus.id_opcode), 64'(OP_NO_OP));
    tick();
    rst = 1'b0;
    bus.id_ready = 1'b1;
    tick();
    check("post_rst_valid", 64'(bus.id_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
